// File: rtl/mc_core_pkg.sv
// rtl/mc_core_pkg.sv - shared types, instruction field positions and branch LUT for mc_core
package mc_core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_AND  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ADDI = 3'd4,
        OP_LD   = 3'd5,
        OP_ST   = 3'd6,
        OP_BR   = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic zero;
        logic par;
        logic sc;
    } flags_t;

    localparam int IW     = 9;
    localparam int FW     = 3;
    localparam int OP_LSB = 6;
    localparam int A_LSB  = 3;
    localparam int B_LSB  = 0;

    localparam int LUT_W = 12;
    localparam int LUT_N = 64;

    // Entry 2 and everything from 16 upward land on the default end address.
    localparam logic [LUT_W-1:0] BR_LUT [LUT_N] = '{
        0: 12'd0,    1: 12'd8,    2: 12'd128,  3: 12'd24,
        4: 12'd32,   5: 12'd40,   6: 12'd48,   7: 12'd56,
        8: 12'd64,   9: 12'd72,   10: 12'd80,  11: 12'd88,
        12: 12'd96,  13: 12'd104, 14: 12'd112, 15: 12'd120,
        default: 12'd128
    };

    function automatic logic [5:0] br_lut_idx(input logic [5:0] ab);
`ifdef MC_CORE_PARITY_BR_EN
        return {1'b0, ab[4:0]};
`else
        return ab;
`endif
    endfunction

endpackage

// File: rtl/mc_core_ctrl.sv
// rtl/mc_core_ctrl.sv - mc_core sequencing FSM, instruction register and PC / next-PC logic
module mc_core_ctrl
    import mc_core_pkg::*;
#(
    parameter int PCW       = 12,
    parameter int DONE_ADDR = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IW-1:0]  imem_data,
    input  logic           dmem_ack,
    input  logic           br_cond,
    output state_e         state,
    output logic [PCW-1:0] pc,
    output logic [IW-1:0]  ir,
    output logic           busy,
    output logic           done
);

    localparam logic [PCW-1:0] DONE_PC = PCW'(DONE_ADDR);

    state_e         state_q;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;
    logic [IW-1:0]  ir_q;
    logic           busy_q;
    logic           done_q;
    opcode_e        op;

    assign op = opcode_e'(ir_q[OP_LSB +: FW]);

    always_comb begin
        pc_d = pc_q + PCW'(1);
        if (op == OP_BR && br_cond) begin
            pc_d = PCW'(BR_LUT[br_lut_idx(ir_q[2*FW-1:0])]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (pc_q == DONE_PC) begin
                        state_q <= ST_HALT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ir_q    <= imem_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op == OP_LD || op == OP_ST) begin
                        state_q <= ST_MEM;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        pc_q    <= pc_q + PCW'(1);
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign pc    = pc_q;
    assign ir    = ir_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle 9-bit-ISA core top; MC_CORE_PARITY_BR_EN selects parity-conditional branches
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DW        = 8,
    parameter int PCW       = 12,
    parameter int DONE_ADDR = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic [PCW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic           dmem_ack,
    output logic           busy,
    output logic           done
);

    state_e         state;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ir;
    logic           br_cond;

    logic [DW-1:0]  rf_q [8];
    flags_t         flags_q;
    flags_t         flags_d;
    logic           req_q;
    logic           we_q;
    logic [DW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;

    opcode_e        op;
    logic [FW-1:0]  fa;
    logic [FW-1:0]  fb;
    logic [DW-1:0]  ra;
    logic [DW-1:0]  rb;
    logic [DW-1:0]  opnd;
    logic [DW:0]    sum;
    logic [DW-1:0]  alu_res;
    logic           alu_op;
    logic           mem_op;

    mc_core_ctrl #(
        .PCW       (PCW),
        .DONE_ADDR (DONE_ADDR)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_data (imem_data),
        .dmem_ack  (dmem_ack),
        .br_cond   (br_cond),
        .state     (state),
        .pc        (pc),
        .ir        (ir),
        .busy      (busy),
        .done      (done)
    );

    assign op     = opcode_e'(ir[OP_LSB +: FW]);
    assign fa     = ir[A_LSB +: FW];
    assign fb     = ir[B_LSB +: FW];
    assign ra     = rf_q[fa];
    assign rb     = rf_q[fb];
    assign opnd   = (op == OP_ADDI) ? DW'(fb) : rb;
    assign sum    = {1'b0, ra} + {1'b0, opnd};
    assign alu_op = (op <= OP_ADDI);
    assign mem_op = (op == OP_LD) || (op == OP_ST);

`ifdef MC_CORE_PARITY_BR_EN
    assign br_cond = ir[A_LSB + FW - 1] ? flags_q.par : flags_q.zero;
`else
    assign br_cond = flags_q.zero;
`endif

    always_comb begin
        alu_res = ra;
        flags_d = flags_q;
        case (op)
            OP_ADD, OP_ADDI: begin
                alu_res    = sum[DW-1:0];
                flags_d.sc = sum[DW];
            end
            OP_AND: alu_res = ra & rb;
            OP_XOR: alu_res = ra ^ rb;
            OP_SHL: begin
                alu_res    = {ra[DW-2:0], flags_q.sc};
                flags_d.sc = ra[DW-1];
            end
            default: ;
        endcase
        if (alu_op) begin
            flags_d.zero = (alu_res == '0);
            flags_d.par  = ^alu_res;
        end
    end

    // Request fields are latched on entry to MEM so they stay stable through any wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
            flags_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (state == ST_EXEC) begin
                if (alu_op) begin
                    rf_q[fa] <= alu_res;
                    flags_q  <= flags_d;
                end
                if (mem_op) begin
                    req_q   <= 1'b1;
                    we_q    <= (op == OP_ST);
                    addr_q  <= rb;
                    wdata_q <= ra;
                end
            end
            if (state == ST_MEM && dmem_ack) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    rf_q[fa] <= dmem_rdata;
                end
            end
        end
    end

    assign imem_addr  = pc;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule
